nios_sys_dtmf_rx: RTL and testbench
===================================

// Module: nios_sys_dtmf_rx
// PURPOSE
//  Receive-side DTMF digit port for the Nios system; the read counterpart of the 4-bit DTMF code output PIO.
//  Samples an external DTMF decoder (MT8870-style: 4-bit code Q[3:0] + delayed-steering strobe StD),
//  qualifies each strobe, pushes the code into a small FIFO and exposes it over an Avalon-MM slave with IRQ.
// PARAMETERS
//  FIFO_DEPTH      8   code FIFO entries; power of 2, 2..64
//  FIFO_AW         3   log2(FIFO_DEPTH)
//  MIN_STD_CYCLES  16  synced StD must stay high this many clk cycles before capture (debounce)
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   reset, asynchronous, active-low
//  address     in   2   Avalon word address
//  chipselect  in   1   Avalon select
//  read_n      in   1   Avalon read strobe, active-low
//  write_n     in   1   Avalon write strobe, active-low
//  writedata   in   32  Avalon write data
//  readdata    out  32  Avalon read data, combinational, 0 wait states
//  dtmf_q      in   4   decoder code, asynchronous to clk
//  dtmf_std    in   1   decoder strobe, asynchronous, active-high
//  irq         out  1   level interrupt
// BEHAVIOUR
//  Reset: FIFO empty, overflow=0, irq_mask=0, enable=0, FSM IDLE, irq=0, readdata reflects empty state.
//  Sync: dtmf_q and dtmf_std each pass a 2-FF synchronizer; all logic uses synced values (2-cycle input latency).
//  Capture FSM (runs only while CTRL.enable=1; enable=0 forces IDLE next cycle, no push):
//   IDLE     : std_s=1 -> QUALIFY, cnt=1
//   QUALIFY  : std_s=0 -> IDLE (glitch, no push); cnt==MIN_STD_CYCLES-1 -> push q_s, go HELD; else cnt++
//   HELD     : std_s=0 -> IDLE; one push per strobe regardless of strobe length
//  Register map (reads/writes act only with chipselect; unused bits read 0):
//   0 DATA   R : [3:0] head code, [8] valid(=!empty). Read with valid=1 pops exactly one entry that cycle;
//              read when empty returns 0, no pop. Writes ignored.
//   1 STATUS R : [0] !empty, [1] full, [2] overflow (sticky), [15:8] count (0..FIFO_DEPTH).
//            W : writedata[2]=1 clears overflow.
//   2 IRQMSK RW: [0] irq on !empty, [1] irq on overflow.
//   3 CTRL   RW: [0] enable capture. W: writedata[1]=1 flushes FIFO (self-clearing, reads 0).
//  irq = (IRQMSK[0] & !empty) | (IRQMSK[1] & overflow); registered, asserts 1 cycle after the cause.
//  FIFO: push when full without same-cycle pop -> code dropped, overflow set. Push+pop same cycle when
//   full -> both occur, count unchanged, no overflow. Push+pop when empty -> pop ignored, push occurs.
//  Flush same cycle as push -> flush wins, FIFO empty, code discarded; overflow not affected by flush.
//  Overflow clear and new overflow same cycle -> overflow stays 1.
//  Pointers FIFO_AW bits, wrap naturally; count FIFO_AW+1 bits, zero-extended into STATUS[15:8].
//  Reset asserted mid-strobe -> all state cleared; strobe still high after release is re-qualified from IDLE
//   only if enable is rewritten to 1 (enable resets to 0).
// STRUCTURE
//  Shared package/include: register offsets (DATA/STATUS/IRQMSK/CTRL), bit positions, FSM state encodings.
//  Sub-module nios_sys_dtmf_rx_fifo: sync FIFO, width 4, depth FIFO_DEPTH; ports push, pop, flush, din,
//   dout, empty, full, count. Top holds synchronizers, capture FSM, registers, read mux, irq.
// TESTING
//  1 enable=1; dtmf_q=4'h5, std high 40 cycles -> one push; DATA read = 0x105, then DATA read = 0x000.
//  2 std high 10 cycles (< MIN_STD_CYCLES) -> no push, STATUS=0; 16+ cycles -> count=1.
//  3 push 9 codes 1..9 with DEPTH 8 -> STATUS full=1, ovf=1, count=8; reads return 1..8; write STATUS bit2 -> ovf=0.
//  4 IRQMSK=1: first capture -> irq=1 one cycle after push; pop last entry -> irq=0 next cycle.
//  5 FIFO full, capture completes same cycle as DATA read -> count stays 8, ovf=0, new code last out.
//  6 flush coinciding with push -> count=0; reset_n low during QUALIFY -> all regs reset, no push after release.

Source files
------------

// File: rtl/nios_sys_dtmf_rx_pkg.sv
// rtl/nios_sys_dtmf_rx_pkg.sv - register map, bit positions and capture FSM encodings for the DTMF receive port
package nios_sys_dtmf_rx_pkg;

    // Avalon word offsets
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_IRQMSK = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // DATA register
    localparam int DATA_VALID_BIT    = 8;

    // STATUS register
    localparam int STATUS_NEMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT   = 1;
    localparam int STATUS_OVF_BIT    = 2;
    localparam int STATUS_COUNT_LSB  = 8;

    // IRQMSK register
    localparam int IRQMSK_NEMPTY_BIT = 0;
    localparam int IRQMSK_OVF_BIT    = 1;

    // CTRL register
    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_FLUSH_BIT    = 1;

    // Capture FSM encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUALIFY = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    // Assemble the STATUS word; count is zero-extended into [15:8].
    function automatic logic [31:0] pack_status(input logic nempty, input logic full,
                                                input logic ovf, input logic [7:0] count);
        logic [31:0] w;
        w = 32'd0;
        w[STATUS_NEMPTY_BIT] = nempty;
        w[STATUS_FULL_BIT]   = full;
        w[STATUS_OVF_BIT]    = ovf;
        w[STATUS_COUNT_LSB +: 8] = count;
        return w;
    endfunction

endpackage

// File: rtl/nios_sys_dtmf_rx_fifo.sv
// rtl/nios_sys_dtmf_rx_fifo.sv - 4-bit synchronous code FIFO with flush
// Ports: clk, reset_n (async active-low); push/din write side; pop/dout read side
// (dout shows the head entry combinationally); flush empties the FIFO and wins over
// a same-cycle push; empty/full/count report occupancy (count is AW+1 bits).
module nios_sys_dtmf_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [3:0]    din,
    output logic [3:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [3:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
        // when a pop frees the head slot in the same cycle.
        do_pop   = pop & ~empty & ~flush;
        do_push  = push & (~full | do_pop) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/nios_sys_dtmf_rx.sv
// rtl/nios_sys_dtmf_rx.sv - DTMF decoder receive port with strobe qualification, code FIFO and Avalon-MM slave
// Ports: clk, reset_n (async active-low); Avalon slave address/chipselect/read_n/write_n/
// writedata/readdata (combinational read, 0 wait states); dtmf_q/dtmf_std from an
// MT8870-style decoder (asynchronous); irq level interrupt (registered).
module nios_sys_dtmf_rx
    import nios_sys_dtmf_rx_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_AW        = 3,
    parameter int MIN_STD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [3:0]  dtmf_q,
    input  logic        dtmf_std,
    output logic        irq
);

    localparam int CNT_W = (MIN_STD_CYCLES > 2) ? $clog2(MIN_STD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_STD_CYCLES - 1);

    // Two-stage synchronizers for the asynchronous decoder outputs
    logic [3:0] q_meta_q, q_meta_d, q_sync_q, q_sync_d;
    logic       std_meta_q, std_meta_d, std_sync_q, std_sync_d;

    // Capture FSM
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cap_push;

    // Registers
    logic       enable_q, enable_d;
    logic [1:0] irq_mask_q, irq_mask_d;
    logic       ovf_q, ovf_d;
    logic       irq_q, irq_d;

    // Bus decode
    logic bus_rd, bus_wr, fifo_pop, fifo_flush, ovf_clr;

    // FIFO interface
    logic [3:0]         fifo_dout;
    logic               fifo_empty, fifo_full;
    logic [FIFO_AW:0]   fifo_count;

    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata[31:3]};

    always_comb begin
        q_meta_d   = dtmf_q;
        q_sync_d   = q_meta_q;
        std_meta_d = dtmf_std;
        std_sync_d = std_meta_q;
    end

    // Capture FSM: a strobe must be seen high for MIN_STD_CYCLES consecutive synced
    // cycles (the IDLE cycle counts as the first) before its code is pushed once.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_push = 1'b0;
        if (!enable_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (std_sync_q) begin
                        state_d = ST_QUALIFY;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_QUALIFY: begin
                    if (!std_sync_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cap_push = 1'b1;
                        state_d  = ST_HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!std_sync_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus_rd     = chipselect & ~read_n;
        bus_wr     = chipselect & ~write_n;
        fifo_pop   = bus_rd & (address == ADDR_DATA) & ~fifo_empty;
        fifo_flush = bus_wr & (address == ADDR_CTRL) & writedata[CTRL_FLUSH_BIT];
        ovf_clr    = bus_wr & (address == ADDR_STATUS) & writedata[STATUS_OVF_BIT];

        enable_d   = enable_q;
        irq_mask_d = irq_mask_q;
        if (bus_wr && address == ADDR_CTRL)   enable_d   = writedata[CTRL_ENABLE_BIT];
        if (bus_wr && address == ADDR_IRQMSK) irq_mask_d = writedata[1:0];

        // A new overflow beats a same-cycle clear.
        ovf_d = (cap_push & fifo_full & ~fifo_pop) | (ovf_q & ~ovf_clr);

        irq_d = (irq_mask_q[IRQMSK_NEMPTY_BIT] & ~fifo_empty) |
                (irq_mask_q[IRQMSK_OVF_BIT] & ovf_q);
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA: begin
                if (!fifo_empty) begin
                    readdata[3:0]           = fifo_dout;
                    readdata[DATA_VALID_BIT] = 1'b1;
                end
            end
            ADDR_STATUS: readdata = pack_status(~fifo_empty, fifo_full, ovf_q, 8'(fifo_count));
            ADDR_IRQMSK: readdata[1:0] = irq_mask_q;
            ADDR_CTRL:   readdata[CTRL_ENABLE_BIT] = enable_q;
            default:     readdata = 32'd0;
        endcase
    end

    assign irq = irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_meta_q   <= '0;
            q_sync_q   <= '0;
            std_meta_q <= 1'b0;
            std_sync_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            enable_q   <= 1'b0;
            irq_mask_q <= '0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            q_meta_q   <= q_meta_d;
            q_sync_q   <= q_sync_d;
            std_meta_q <= std_meta_d;
            std_sync_q <= std_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            enable_q   <= enable_d;
            irq_mask_q <= irq_mask_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
        end
    end

    nios_sys_dtmf_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cap_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .din     (q_sync_q),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_nios_sys_dtmf_rx.sv
// tb/tb_nios_sys_dtmf_rx.sv - self-checking bench for the DTMF receive port
module tb_nios_sys_dtmf_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  dtmf_q = 4'd0;
    logic        dtmf_std = 1'b0;
    logic        irq;

    int n_cmp = 0;
    int n_fail = 0;

    nios_sys_dtmf_rx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .dtmf_q     (dtmf_q),
        .dtmf_std   (dtmf_std),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: queue of codes, sticky overflow, interrupt mask.
    localparam int DEPTH = 8;
    localparam int MIN_STD = 16;
    logic [3:0] mq[$];
    bit         m_ovf;
    logic [1:0] m_mask;

    typedef struct {
        int          len;
        logic [3:0]  code;
        logic [31:0] exp_status;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        #1 d = readdata;
        @(posedge clk);
        #1 chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(posedge clk);
        #1 chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic strobe(input logic [3:0] code, input int n);
        @(negedge clk);
        dtmf_q = code; dtmf_std = 1'b1;
        repeat (n) @(negedge clk);
        dtmf_std = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] w;
        w = 32'd0;
        w[0] = (mq.size() != 0);
        w[1] = (mq.size() == DEPTH);
        w[2] = m_ovf;
        w[15:8] = 8'(mq.size());
        return w;
    endfunction

    function automatic logic m_irq();
        return (m_mask[0] && mq.size() != 0) || (m_mask[1] && m_ovf);
    endfunction

    task automatic m_strobe(input logic [3:0] code, input int n);
        if (n >= MIN_STD) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(code);
        end
    endtask

    function automatic logic [31:0] m_pop();
        logic [31:0] w;
        w = 32'd0;
        if (mq.size() != 0) begin
            w = {23'd0, 1'b1, 4'd0, mq.pop_front()};
        end
        return w;
    endfunction

    initial begin
        logic [31:0] rd;
        int push_edge, irq_edge;

        // Reset state
        repeat (3) @(negedge clk);
        #1 check("reset_irq", {31'd0, irq}, 32'd0);
        address = 2'd0; #1 check("reset_data", readdata, 32'd0);
        address = 2'd1; #1 check("reset_status", readdata, 32'd0);
        reset_n = 1'b1;
        bus_read(2'd2, rd); check("reset_irqmsk", rd, 32'd0);
        bus_read(2'd3, rd); check("reset_ctrl", rd, 32'd0);

        // Strobe while disabled: nothing captured
        strobe(4'h9, 30);
        bus_read(2'd1, rd); check("disabled_no_push", rd, 32'd0);

        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rd); check("ctrl_enable", rd, 32'h1);

        // Test 1: long strobe pushes once, second read empty
        strobe(4'h5, 40);
        bus_read(2'd0, rd); check("t1_data", rd, 32'h105);
        bus_read(2'd0, rd); check("t1_empty", rd, 32'h000);

        // Table: strobe lengths around the debounce threshold
        vecs[0] = '{10, 4'hA, 32'h0000};
        vecs[1] = '{15, 4'hB, 32'h0000};
        vecs[2] = '{16, 4'hC, 32'h0101};
        vecs[3] = '{40, 4'hD, 32'h0201};
        vecs[4] = '{2,  4'hE, 32'h0201};
        vecs[5] = '{17, 4'hF, 32'h0301};
        for (int i = 0; i < 6; i++) begin
            strobe(vecs[i].code, vecs[i].len);
            bus_read(2'd1, rd);
            check($sformatf("vec%0d_status", i), rd, vecs[i].exp_status);
        end
        bus_read(2'd0, rd); check("vec_pop0", rd, 32'h10C);
        bus_read(2'd0, rd); check("vec_pop1", rd, 32'h10D);
        bus_read(2'd0, rd); check("vec_pop2", rd, 32'h10F);
        bus_read(2'd0, rd); check("vec_pop3", rd, 32'h000);

        // Test 3: overflow
        for (int i = 1; i <= 9; i++) strobe(4'(i), 20);
        bus_read(2'd1, rd); check("t3_status_full", rd, 32'h0807);
        for (int i = 1; i <= 8; i++) begin
            bus_read(2'd0, rd); check($sformatf("t3_pop%0d", i), rd, 32'h100 | i);
        end
        bus_read(2'd1, rd); check("t3_ovf_sticky", rd, 32'h0004);
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, rd); check("t3_ovf_clear", rd, 32'h0000);

        // Test 4: irq timing relative to the push edge
        bus_write(2'd2, 32'h1);
        push_edge = -1; irq_edge = -1;
        @(negedge clk);
        dtmf_q = 4'h3; dtmf_std = 1'b1;
        address = 2'd1; chipselect = 1'b1; read_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (push_edge < 0 && readdata[15:8] == 8'd1) push_edge = k;
            if (irq_edge < 0 && irq) irq_edge = k;
        end
        chipselect = 1'b0; read_n = 1'b1; dtmf_std = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_push_latency", 32'(push_edge), 32'd18);
        check("t4_irq_latency", 32'(irq_edge), 32'd19);
        bus_read(2'd0, rd); check("t4_pop", rd, 32'h103);
        check("t4_irq_held", {31'd0, irq}, 32'd1);
        @(posedge clk); #1 check("t4_irq_drop", {31'd0, irq}, 32'd0);
        bus_write(2'd2, 32'h0);

        // Test 5: full FIFO, capture coincides with DATA read
        for (int i = 1; i <= 8; i++) strobe(4'(i), 20);
        @(negedge clk);
        dtmf_q = 4'h9; dtmf_std = 1'b1;
        repeat (17) @(negedge clk);
        address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
        #1 rd = readdata;
        @(posedge clk);
        #1 chipselect = 1'b0; read_n = 1'b1;
        check("t5_pop_head", rd, 32'h101);
        repeat (5) @(negedge clk);
        dtmf_std = 1'b0;
        repeat (6) @(negedge clk);
        bus_read(2'd1, rd); check("t5_status", rd, 32'h0803);
        for (int i = 2; i <= 9; i++) begin
            bus_read(2'd0, rd); check($sformatf("t5_pop%0d", i), rd, 32'h100 | i);
        end

        // Randomized phase against the model
        mq.delete(); m_ovf = 1'b0; m_mask = 2'($urandom_range(0, 3));
        bus_write(2'd2, {30'd0, m_mask});
        for (int it = 0; it < 40; it++) begin
            int op, len;
            logic [3:0] code;
            op = $urandom_range(0, 5);
            case (op)
                0, 1: begin
                    len = $urandom_range(12, 22);
                    code = 4'($urandom);
                    strobe(code, len);
                    m_strobe(code, len);
                end
                2: begin
                    bus_read(2'd0, rd);
                    check($sformatf("rnd%0d_data", it), rd, m_pop());
                end
                3: begin
                    bus_read(2'd1, rd);
                    check($sformatf("rnd%0d_status", it), rd, m_status());
                end
                4: begin
                    bus_write(2'd1, 32'h4);
                    m_ovf = 1'b0;
                end
                default: begin
                    m_mask = 2'($urandom_range(0, 3));
                    bus_write(2'd2, {30'd0, m_mask});
                end
            endcase
            @(negedge clk); @(negedge clk);
            check($sformatf("rnd%0d_irq", it), {31'd0, irq}, {31'd0, m_irq()});
        end
        bus_write(2'd2, 32'h0);
        bus_write(2'd1, 32'h4);
        for (int i = 0; i < DEPTH; i++) bus_read(2'd0, rd);
        bus_read(2'd1, rd); check("rnd_drained", rd, 32'h0);

        // Test 6a: flush coincides with the push
        strobe(4'h1, 20);
        strobe(4'h2, 20);
        @(negedge clk);
        dtmf_q = 4'h7; dtmf_std = 1'b1;
        repeat (17) @(negedge clk);
        address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h3;
        @(posedge clk);
        #1 chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        repeat (5) @(negedge clk);
        dtmf_std = 1'b0;
        repeat (6) @(negedge clk);
        bus_read(2'd1, rd); check("t6_flush_status", rd, 32'h0);
        bus_read(2'd3, rd); check("t6_ctrl_after_flush", rd, 32'h1);

        // Test 6b: reset during QUALIFY
        bus_write(2'd2, 32'h3);
        @(negedge clk);
        dtmf_q = 4'h4; dtmf_std = 1'b1;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        dtmf_std = 1'b0;
        repeat (6) @(negedge clk);
        bus_read(2'd1, rd); check("t6_rst_status", rd, 32'h0);
        bus_read(2'd2, rd); check("t6_rst_irqmsk", rd, 32'h0);
        bus_read(2'd3, rd); check("t6_rst_ctrl", rd, 32'h0);
        bus_read(2'd0, rd); check("t6_rst_data", rd, 32'h0);
        check("t6_rst_irq", {31'd0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
